// File: rtl/pong_pkg.sv
// Shared types and constants for the two-player LED pong responder.
//   pong_state_e : game state (serve, rally in each direction, point flash, game over)
//   loser_e      : side that lost the last point, who serves next
//   LED_*        : LEDR patterns for the two edges and the all-on flash
//   sat_inc      : score increment that saturates at a limit
package pong_pkg;

  typedef enum logic [2:0] {
    StServeL,
    StServeR,
    StMoveL,
    StMoveR,
    StPoint,
    StOver
  } pong_state_e;

  typedef enum logic {
    LoserL,
    LoserR
  } loser_e;

  localparam logic [9:0] LED_LEFT  = 10'b10_0000_0000;
  localparam logic [9:0] LED_RIGHT = 10'b00_0000_0001;
  localparam logic [9:0] LED_ALL   = 10'h3FF;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/pong_responder_if.sv
// Board-level signal bundle of the pong responder.
//   KEY_L / KEY_R : active-low player buttons (asynchronous to the clock)
//   LEDR          : ball position (one-hot) or flash pattern
//   SCORE_L/R     : binary scores for the HEX display block
//   GAME_OVER     : high once the game has ended
// master drives the keys and observes the display; slave is the responder.
interface pong_responder_if;
  logic       KEY_L;
  logic       KEY_R;
  logic [9:0] LEDR;
  logic [3:0] SCORE_L;
  logic [3:0] SCORE_R;
  logic       GAME_OVER;

  modport master (
    output KEY_L,
    output KEY_R,
    input  LEDR,
    input  SCORE_L,
    input  SCORE_R,
    input  GAME_OVER
  );

  modport slave (
    input  KEY_L,
    input  KEY_R,
    output LEDR,
    output SCORE_L,
    output SCORE_R,
    output GAME_OVER
  );
endinterface

// File: rtl/key_sync_edge.sv
// Button conditioner: 2-FF synchronizer followed by a falling-edge detector.
//   CLOCK_50 : system clock
//   RST_N    : asynchronous active-low reset
//   key_ni   : raw active-low button, asynchronous to CLOCK_50
//   press_o  : one-cycle pulse per press; the pulse is consumed on the third
//              clock edge after the key goes low. Holding the key gives no more pulses.
module key_sync_edge (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic key_ni,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q;

  // Reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/pong_responder.sv
// Two-player LED pong: ball scanner that bounces only when the edge player returns it.
//   CLOCK_50 : system clock
//   RST_N    : asynchronous active-low reset
//   bus      : keys in; LEDR, scores and GAME_OVER out (all outputs registered)
// The ball advances once every TICK_MAX+1 clocks. A miss scores for the opponent,
// flashes all LEDs for POINT_TICKS ticks, then the loser serves. A score reaching
// WIN_SCORE ends the game with a blinking display until reset.
module pong_responder
  import pong_pkg::*;
#(
  parameter logic [23:0] TICK_MAX    = 24'hFFFFFF,
  parameter logic [3:0]  WIN_SCORE   = 4'd9,
  parameter int unsigned POINT_TICKS = 2
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  pong_responder_if.slave  bus
);

  localparam logic [7:0] PointLast = 8'(POINT_TICKS - 1);

  logic        press_l, press_r;
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic        tick;

  pong_state_e state_q;
  loser_e      loser_q;
  logic [9:0]  ledr_q;
  logic [3:0]  score_l_q, score_r_q;
  logic        game_over_q;
  logic        hit_l_q, hit_r_q;
  logic [7:0]  pt_cnt_q;

  key_sync_edge u_sync_l (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .key_ni   (bus.KEY_L),
    .press_o  (press_l)
  );

  key_sync_edge u_sync_r (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .key_ni   (bus.KEY_R),
    .press_o  (press_r)
  );

  // Free-running tick divider, active in every state.
  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 24'd1;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StServeL;
      loser_q     <= LoserL;
      ledr_q      <= LED_LEFT;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      pt_cnt_q    <= '0;
    end else begin
      // Hit flags only arm while the ball sits on that player's edge; every tick
      // consumes them. On the tick itself the live press is OR-ed in below.
      if (tick) begin
        hit_l_q <= 1'b0;
        hit_r_q <= 1'b0;
      end else begin
        if (state_q == StMoveR && ledr_q[0] && press_r) hit_r_q <= 1'b1;
        if (state_q == StMoveL && ledr_q[9] && press_l) hit_l_q <= 1'b1;
      end

      case (state_q)
        StServeL: begin
          if (press_l) state_q <= StMoveR;
        end

        StServeR: begin
          if (press_r) state_q <= StMoveL;
        end

        StMoveR: begin
          if (tick) begin
            if (ledr_q != LED_RIGHT) begin
              ledr_q <= ledr_q >> 1;
            end else if (hit_r_q || press_r) begin
              state_q <= StMoveL;
              ledr_q  <= ledr_q << 1;
            end else begin
              score_l_q <= sat_inc(score_l_q, WIN_SCORE);
              ledr_q    <= LED_ALL;
              loser_q   <= LoserR;
              pt_cnt_q  <= '0;
              state_q   <= StPoint;
            end
          end
        end

        StMoveL: begin
          if (tick) begin
            if (ledr_q != LED_LEFT) begin
              ledr_q <= ledr_q << 1;
            end else if (hit_l_q || press_l) begin
              state_q <= StMoveR;
              ledr_q  <= ledr_q >> 1;
            end else begin
              score_r_q <= sat_inc(score_r_q, WIN_SCORE);
              ledr_q    <= LED_ALL;
              loser_q   <= LoserL;
              pt_cnt_q  <= '0;
              state_q   <= StPoint;
            end
          end
        end

        StPoint: begin
          if (tick) begin
            if (pt_cnt_q == PointLast) begin
              pt_cnt_q <= '0;
              if (score_l_q == WIN_SCORE || score_r_q == WIN_SCORE) begin
                // LEDR is already all-on, which is the first blink phase.
                state_q     <= StOver;
                game_over_q <= 1'b1;
              end else if (loser_q == LoserL) begin
                state_q <= StServeL;
                ledr_q  <= LED_LEFT;
              end else begin
                state_q <= StServeR;
                ledr_q  <= LED_RIGHT;
              end
            end else begin
              pt_cnt_q <= pt_cnt_q + 8'd1;
            end
          end
        end

        StOver: begin
          if (tick) ledr_q <= ~ledr_q;
        end

        default: begin
          state_q <= StServeL;
          ledr_q  <= LED_LEFT;
        end
      endcase
    end
  end

  assign bus.LEDR      = ledr_q;
  assign bus.SCORE_L   = score_l_q;
  assign bus.SCORE_R   = score_r_q;
  assign bus.GAME_OVER = game_over_q;

endmodule

// File: tb/tb_pong_responder.sv
// Self-checking bench for pong_responder with TICK_MAX=3 (one tick every 4 clocks).
// A behavioural game model (integer ball position, per-side scores) tracks the DUT;
// one compare process checks every output on every falling edge, and directed
// scenarios add literal expectations at key moments.
module tb_pong_responder;

  localparam int TickPeriod = 4;
  localparam int WinScore   = 9;
  localparam int PointTicks = 2;

  logic clk;
  logic rst_n;
  bit   cmp_en;
  int   checks;
  int   errors;

  pong_responder_if bus ();

  pong_responder #(
    .TICK_MAX    (24'd3),
    .WIN_SCORE   (4'd9),
    .POINT_TICKS (2)
  ) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 serving, 1 rally, 2 point flash, 3 game over
  // side : 0 = left (LED 9), 1 = right (LED 0); in a rally, the side the ball heads to
  int       m_edges;
  int       m_phase;
  int       m_side;
  int       m_pos;
  bit       m_hit;
  int       m_score[2];
  int       m_flash;
  int       m_loser;
  bit       m_blink;
  bit [2:0] m_hist_l, m_hist_r;

  function automatic int edge_pos(input int side);
    return (side == 0) ? 9 : 0;
  endfunction

  function automatic int step_dir(input int side);
    return (side == 0) ? 1 : -1;
  endfunction

  function automatic logic [9:0] exp_led();
    logic [9:0] one;
    one = 10'd1;
    if (m_phase == 2) return 10'h3FF;
    if (m_phase == 3) return m_blink ? 10'h3FF : 10'h000;
    return one << m_pos;
  endfunction

  task automatic model_reset();
    m_edges    = 0;
    m_phase    = 0;
    m_side     = 0;
    m_pos      = 9;
    m_hit      = 1'b0;
    m_score[0] = 0;
    m_score[1] = 0;
    m_flash    = 0;
    m_loser    = 0;
    m_blink    = 1'b0;
    m_hist_l   = 3'b111;
    m_hist_r   = 3'b111;
  endtask

  task automatic model_step();
    bit       tick;
    bit [1:0] p;
    bit       at_edge;
    tick     = (m_edges % TickPeriod) == (TickPeriod - 1);
    m_edges  = m_edges + 1;
    // A key level seen low after being high two samples earlier is one press.
    p[0]     = m_hist_l[2] & ~m_hist_l[1];
    p[1]     = m_hist_r[2] & ~m_hist_r[1];
    m_hist_l = {m_hist_l[1:0], bus.KEY_L};
    m_hist_r = {m_hist_r[1:0], bus.KEY_R};
    case (m_phase)
      0: begin
        if (p[m_side]) begin
          m_phase = 1;
          m_side  = 1 - m_side;
          m_hit   = 1'b0;
        end
      end
      1: begin
        at_edge = (m_pos == edge_pos(m_side));
        if (tick) begin
          if (!at_edge) begin
            m_pos = m_pos + step_dir(m_side);
          end else if (m_hit || p[m_side]) begin
            m_side = 1 - m_side;
            m_pos  = m_pos + step_dir(m_side);
          end else begin
            if (m_score[1 - m_side] < WinScore) m_score[1 - m_side]++;
            m_phase = 2;
            m_flash = PointTicks;
            m_loser = m_side;
          end
          m_hit = 1'b0;
        end else if (at_edge && p[m_side]) begin
          m_hit = 1'b1;
        end
      end
      2: begin
        if (tick) begin
          m_flash--;
          if (m_flash == 0) begin
            if (m_score[0] == WinScore || m_score[1] == WinScore) begin
              m_phase = 3;
              m_blink = 1'b1;
            end else begin
              m_phase = 0;
              m_side  = m_loser;
              m_pos   = edge_pos(m_loser);
            end
          end
        end
      end
      default: begin
        if (tick) m_blink = ~m_blink;
      end
    endcase
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("LEDR", int'(bus.LEDR), int'(exp_led()));
      check("SCORE_L", int'(bus.SCORE_L), m_score[0]);
      check("SCORE_R", int'(bus.SCORE_R), m_score[1]);
      check("GAME_OVER", int'(bus.GAME_OVER), (m_phase == 3) ? 1 : 0);
    end
  end

  // Wait (bounded) until LEDR equals v (eq=1) or differs from v (eq=0).
  task automatic wait_led(input logic [9:0] v, input bit eq, input string tag);
    int n;
    n = 0;
    while (((bus.LEDR == v) != eq) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: LEDR %0h", tag, bus.LEDR);
    end
  endtask

  task automatic press(input bit l, input bit r, input int hold);
    if (l) bus.KEY_L = 1'b0;
    if (r) bus.KEY_R = 1'b0;
    repeat (hold) @(negedge clk);
    bus.KEY_L = 1'b1;
    bus.KEY_R = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cmp_en    = 1'b0;
    rst_n     = 1'b0;
    bus.KEY_L = 1'b1;
    bus.KEY_R = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_LEDR", int'(bus.LEDR), 'h200);
    check("rst_SCORE_L", int'(bus.SCORE_L), 0);
    check("rst_SCORE_R", int'(bus.SCORE_R), 0);
    check("rst_GAME_OVER", int'(bus.GAME_OVER), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Idle for 20 ticks: ball stays parked on the left.
    repeat (80) @(negedge clk);
    check("idle_LEDR", int'(bus.LEDR), 'h200);

    // Left serves; left key mid-rally is ignored; right misses.
    press(1'b1, 1'b0, 4);
    wait_led(10'h010, 1'b1, "bit4");
    press(1'b1, 1'b0, 4);
    wait_led(10'h001, 1'b1, "reach_r");
    wait_led(10'h3FF, 1'b1, "flash1");
    check("miss1_SCORE_L", int'(bus.SCORE_L), 1);
    wait_led(10'h3FF, 1'b0, "flash1_end");
    check("serve_r_LEDR", int'(bus.LEDR), 'h001);

    // Right serves, left misses: serve goes back to the left.
    press(1'b0, 1'b1, 4);
    wait_led(10'h200, 1'b1, "reach_l");
    wait_led(10'h3FF, 1'b1, "flash2");
    check("miss2_SCORE_R", int'(bus.SCORE_R), 1);
    wait_led(10'h3FF, 1'b0, "flash2_end");
    check("serve_l_LEDR", int'(bus.LEDR), 'h200);

    // Return with KEY_R held low through the edge window.
    press(1'b1, 1'b0, 4);
    wait_led(10'h001, 1'b1, "reach_r2");
    bus.KEY_R = 1'b0;
    wait_led(10'h001, 1'b0, "ret_r");
    check("ret_r_LEDR", int'(bus.LEDR), 'h002);
    repeat (4) @(negedge clk);
    bus.KEY_R = 1'b1;
    wait_led(10'h200, 1'b1, "reach_l2");
    press(1'b1, 1'b0, 4);
    wait_led(10'h200, 1'b0, "ret_l");
    check("ret_l_LEDR", int'(bus.LEDR), 'h100);
    // Press lands exactly on the edge tick cycle.
    wait_led(10'h001, 1'b1, "reach_r3");
    @(negedge clk);
    press(1'b0, 1'b1, 4);
    wait_led(10'h001, 1'b0, "ret_r_tick");
    check("ret_tick_LEDR", int'(bus.LEDR), 'h002);
    wait_led(10'h3FF, 1'b1, "flash3");
    check("miss3_SCORE_R", int'(bus.SCORE_R), 2);
    wait_led(10'h3FF, 1'b0, "flash3_end");

    // Both keys in SERVE_L launch right; an early right press is a miss.
    press(1'b1, 1'b1, 4);
    wait_led(10'h200, 1'b0, "launch");
    check("launch_LEDR", int'(bus.LEDR), 'h100);
    wait_led(10'h008, 1'b1, "bit3");
    press(1'b0, 1'b1, 4);
    wait_led(10'h3FF, 1'b1, "flash4");
    check("early_SCORE_L", int'(bus.SCORE_L), 2);
    wait_led(10'h3FF, 1'b0, "flash4_end");
    check("serve_r2_LEDR", int'(bus.LEDR), 'h001);

    // Right serves, left returns, right misses: until the left wins.
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 1'b1, 4);
      wait_led(10'h200, 1'b1, "loop_l");
      press(1'b1, 1'b0, 4);
      wait_led(10'h3FF, 1'b1, "loop_flash");
      wait_led(10'h3FF, 1'b0, "loop_end");
    end
    check("win_SCORE_L", int'(bus.SCORE_L), 9);
    check("win_SCORE_R", int'(bus.SCORE_R), 2);
    check("win_GAME_OVER", int'(bus.GAME_OVER), 1);
    check("blink0_LEDR", int'(bus.LEDR), 'h000);

    // Keys ignored while blinking.
    press(1'b1, 1'b1, 4);
    wait_led(10'h000, 1'b0, "blink1");
    check("blink1_LEDR", int'(bus.LEDR), 'h3FF);
    wait_led(10'h3FF, 1'b0, "blink2");
    check("blink2_LEDR", int'(bus.LEDR), 'h000);
    wait_led(10'h000, 1'b0, "blink3");

    // Asynchronous reset mid-blink.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_LEDR", int'(bus.LEDR), 'h200);
    check("mid_rst_SCORE_L", int'(bus.SCORE_L), 0);
    check("mid_rst_SCORE_R", int'(bus.SCORE_R), 0);
    check("mid_rst_GAME_OVER", int'(bus.GAME_OVER), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_LEDR", int'(bus.LEDR), 'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
